// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch sequencer with PC register.
// Optional feature macro: FETCH_TIMEOUT_EN. When it is defined, a WAIT-state
// watchdog is built. The watchdog sets a sticky fetch_err and re-issues the
// stalled read.
module fetch_unit #(
    parameter logic [15:0] RESET_PC    = 16'h3000,
    parameter int          TIMEOUT_CYC = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_fetch,
    input  logic        enable_updatePC,
    input  logic        br_taken,
    input  logic [15:0] taddr,
    input  logic [15:0] imem_dout,
    input  logic        imem_ready,
    output logic [15:0] imem_addr,
    output logic        imem_rd,
    output logic [15:0] pc,
    output logic [15:0] npc,
    output logic [15:0] IR,
    output logic        complete_instr,
    output logic        fetch_err
);

    // RETRY is the one-cycle request gap after a timeout.
    // It is unreachable when the watchdog is not built.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        DONE  = 2'd2,
        RETRY = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q;
    logic [15:0] ir_q;
    logic [15:0] addr_q;
    logic        complete_q;
    logic        abort_q;      // enable_fetch dropped during this access
    logic        timeout_hit;

    // The access is kept only if the controller still wants it when data arrives.
    logic        accept_data;
    assign accept_data = (state_q == WAIT) && imem_ready && enable_fetch && !abort_q;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    logic [7:0] wait_cnt_q;
    logic       err_q;

    // The edge that would bring the count to TIMEOUT_CYC is the timeout edge.
    assign timeout_hit = (state_q == WAIT) && !imem_ready && (wait_cnt_q == TIMEOUT_LAST);

    // Count stalled WAIT cycles. The count is zero on every WAIT entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            wait_cnt_q <= 8'd0;
        end else if (state_q != WAIT || timeout_hit) begin
            wait_cnt_q <= 8'd0;
        end else if (!imem_ready) begin
            wait_cnt_q <= wait_cnt_q + 8'd1;
        end
    end

    // Sticky timeout flag. Only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign fetch_err = err_q;
`else
    // No watchdog: WAIT lasts until the memory answers.
    assign timeout_hit = 1'b0;
    assign fetch_err   = 1'b0;
`endif

    // Next-state logic for the fetch handshake.
    always_comb begin
        // NOTE: assigning a default before the case means every path drives
        // state_d, so no latch is inferred.
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (enable_fetch) state_d = WAIT;
            WAIT: begin
                if (imem_ready)       state_d = accept_data ? DONE : IDLE;
                else if (timeout_hit) state_d = RETRY;
            end
            DONE:  if (!enable_fetch) state_d = IDLE;
            RETRY: state_d = WAIT;
            default: state_d = IDLE;
        endcase
    end

    // State register and registered completion decode.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values. That behaviour lets imem_addr capture the
        // old pc when pc changes on the same edge.
        if (reset) begin
            state_q    <= IDLE;
            complete_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            complete_q <= (state_d == DONE);
        end
    end

    // The PC updates on the strobe in any FSM state. Arithmetic wraps modulo 2^16.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (enable_updatePC) begin
            pc_q <= br_taken ? taddr : pc_q + 16'd1;
        end
    end

    // The fetch address is latched on IDLE->WAIT and held through WAIT and RETRY.
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= 16'h0000;
        end else if (state_q == IDLE && enable_fetch) begin
            addr_q <= pc_q;
        end
    end

    // Track an abandoned access. Its data must not reach IR.
    always_ff @(posedge clock) begin
        if (reset) begin
            abort_q <= 1'b0;
        end else if (state_q == IDLE) begin
            abort_q <= 1'b0;
        end else if (state_q == WAIT && !enable_fetch) begin
            abort_q <= 1'b1;
        end
    end

    // The instruction register captures read data only for a wanted access.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q <= 16'h0000;
        end else if (accept_data) begin
            ir_q <= imem_dout;
        end
    end

    assign imem_rd        = (state_q == WAIT);
    assign imem_addr      = addr_q;
    assign pc             = pc_q;
    assign npc            = pc_q + 16'd1;
    assign IR             = ir_q;
    assign complete_instr = complete_q;

endmodule
